// File: rtl/mc_pkg.sv
// Shared types and helpers for the matrix_engine coprocessor.
package mc_pkg;

   // Host command opcodes
   typedef enum logic [2:0] {
      CMD_NOP     = 3'd0,
      CMD_LOAD_A  = 3'd1,
      CMD_LOAD_B  = 3'd2,
      CMD_MUL     = 3'd3,
      CMD_ADD     = 3'd4,
      CMD_TRANS   = 3'd5,
      CMD_COPY_CA = 3'd6,
      CMD_RSVD    = 3'd7
   } cmd_t;

   // Engine control states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   // Dot-product accumulator width: full 2W products plus growth for N terms
   function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
      return 2 * w + $clog2(n);
   endfunction

   // Bit offset of element (i,j) in a row-major packed N x N matrix
   function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j,
                                            input int unsigned n, input int unsigned w);
      return (i * n + j) * w;
   endfunction

endpackage

// File: rtl/mc_dot_unit.sv
// Combinational signed dot product of one row of A with one column of B.
module mc_dot_unit
   import mc_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 21
) (
   input  logic [N*W-1:0] i_row,
   input  logic [N*W-1:0] i_col,
   output logic [W-1:0]   o_result,
   output logic           o_overflow
);

   localparam int unsigned AW = acc_width(W, N);

   logic signed [2*W-1:0] w_prod [N];
   logic signed [AW-1:0]  w_acc;

   // Full-precision products and exact accumulation
   always_comb begin
      w_acc = '0;
      for (int unsigned j = 0; j < N; j++) begin
         w_prod[j] = (2*W)'($signed(i_row[j*W +: W])) * (2*W)'($signed(i_col[j*W +: W]));
         w_acc     = w_acc + AW'(w_prod[j]);
      end
   end

   // Wrap to W bits; out of range when the bits above the W-bit sign disagree
   always_comb begin
      o_result   = w_acc[W-1:0];
      o_overflow = !((&w_acc[AW-1:W-1]) || !(|w_acc[AW-1:W-1]));
   end

endmodule

// File: rtl/matrix_engine.sv
// N x N signed matrix coprocessor: load, multiply, add, transpose, copy-back.
module matrix_engine
   import mc_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 21
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       command,
   input  logic [N*N*W-1:0] Matrix_in,
   output logic [N*N*W-1:0] Matrix_out,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   localparam int unsigned NE = N * N;
   localparam int unsigned MW = NE * W;
   localparam int unsigned KW = $clog2(NE);
   localparam int unsigned RW = $clog2(N);

   state_t          r_state;
   state_t          w_state_next;
   logic [KW-1:0]   r_k;
   logic [MW-1:0]   r_a;
   logic [MW-1:0]   r_b;
   logic [MW-1:0]   r_c;
   logic            r_done;
   logic            r_out_valid;
   logic            r_overflow;
   logic            r_sets_valid;

   cmd_t            w_cmd;
   logic            w_accept;
   logic            w_last_k;
   logic [RW-1:0]   w_i;
   logic [RW-1:0]   w_j;
   logic [N*W-1:0]  w_row;
   logic [N*W-1:0]  w_col;
   logic [W-1:0]    w_dot_res;
   logic            w_dot_ovf;
   logic [MW-1:0]   w_add;
   logic            w_add_ovf;
   logic [MW-1:0]   w_trans;
   logic [W:0]      w_sum;

   assign w_cmd    = cmd_t'(command);
   assign w_accept = cmd_valid && (r_state == S_IDLE);
   assign w_last_k = (r_k == KW'(NE - 1));
   assign w_i      = RW'(r_k / KW'(N));
   assign w_j      = RW'(r_k % KW'(N));

   // Select row k/N of A and column k%N of B for the shared dot unit
   always_comb begin
      w_row = '0;
      w_col = '0;
      for (int unsigned t = 0; t < N; t++) begin
         w_row[t*W +: W] = r_a[elem_lsb(32'(w_i), t, N, W) +: W];
         w_col[t*W +: W] = r_b[elem_lsb(t, 32'(w_j), N, W) +: W];
      end
   end

   mc_dot_unit #(
      .N (N),
      .W (W)
   ) u_dot (
      .i_row      (w_row),
      .i_col      (w_col),
      .o_result   (w_dot_res),
      .o_overflow (w_dot_ovf)
   );

   // Element-wise A+B at W+1 bits and A transpose
   always_comb begin
      w_add     = '0;
      w_add_ovf = 1'b0;
      w_trans   = '0;
      w_sum     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            w_sum = (W+1)'($signed(r_a[elem_lsb(i, j, N, W) +: W]))
                  + (W+1)'($signed(r_b[elem_lsb(i, j, N, W) +: W]));
            w_add[elem_lsb(i, j, N, W) +: W] = w_sum[W-1:0];
            if (w_sum[W] != w_sum[W-1]) begin
               w_add_ovf = 1'b1;
            end
            w_trans[elem_lsb(i, j, N, W) +: W] = r_a[elem_lsb(j, i, N, W) +: W];
         end
      end
   end

   // State register
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded handshake outputs
   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (w_cmd)
                  CMD_LOAD_A, CMD_LOAD_B, CMD_ADD,
                  CMD_TRANS, CMD_COPY_CA: w_state_next = S_FINISH;
                  CMD_MUL:                w_state_next = S_RUN;
                  default:                w_state_next = S_IDLE;
               endcase
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last_k) begin
               w_state_next = S_FINISH;
            end
         end
         S_FINISH: begin
            busy         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Operand/result registers, element counter and status flags
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_k          <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_c          <= '0;
         r_done       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_overflow   <= 1'b0;
         r_sets_valid <= 1'b0;
      end else begin
         r_done <= (w_state_next == S_FINISH);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  case (w_cmd)
                     CMD_LOAD_A: begin
                        r_a          <= Matrix_in;
                        r_sets_valid <= 1'b0;
                     end
                     CMD_LOAD_B: begin
                        r_b          <= Matrix_in;
                        r_sets_valid <= 1'b0;
                     end
                     CMD_MUL: begin
                        r_k          <= '0;
                        r_out_valid  <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_sets_valid <= 1'b1;
                     end
                     CMD_ADD: begin
                        r_c          <= w_add;
                        r_overflow   <= w_add_ovf;
                        r_sets_valid <= 1'b1;
                     end
                     CMD_TRANS: begin
                        r_c          <= w_trans;
                        r_overflow   <= 1'b0;
                        r_sets_valid <= 1'b1;
                     end
                     CMD_COPY_CA: begin
                        r_a          <= r_c;
                        r_sets_valid <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               r_c[elem_lsb(32'(w_i), 32'(w_j), N, W) +: W] <= w_dot_res;
               if (w_dot_ovf) begin
                  r_overflow <= 1'b1;
               end
               if (w_last_k) begin
                  r_k <= '0;
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            S_FINISH: begin
               if (r_sets_valid) begin
                  r_out_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign Matrix_out = r_c;
   assign out_valid  = r_out_valid;
   assign done       = r_done;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_matrix_engine.sv
// Directed self-checking bench for matrix_engine at 4x4/21-bit and 2x2/8-bit.
module tb_matrix_engine;

   localparam int unsigned N4 = 4;
   localparam int unsigned W4 = 21;
   localparam int unsigned N2 = 2;
   localparam int unsigned W2 = 8;

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_LOAD_A  = 3'd1;
   localparam logic [2:0] OP_LOAD_B  = 3'd2;
   localparam logic [2:0] OP_MUL     = 3'd3;
   localparam logic [2:0] OP_ADD     = 3'd4;
   localparam logic [2:0] OP_TRANS   = 3'd5;
   localparam logic [2:0] OP_COPY_CA = 3'd6;
   localparam logic [2:0] OP_RSVD    = 3'd7;

   typedef logic [N4*N4*W4-1:0] m4_t;
   typedef logic [N2*N2*W2-1:0] m2_t;

   logic       clk;
   logic       rst;

   logic       d4_cmd_valid, d4_cmd_ready, d4_out_valid, d4_busy, d4_done, d4_overflow;
   logic [2:0] d4_command;
   m4_t        d4_in, d4_out;

   logic       d2_cmd_valid, d2_cmd_ready, d2_out_valid, d2_busy, d2_done, d2_overflow;
   logic [2:0] d2_command;
   m2_t        d2_in, d2_out;

   int errors = 0;
   int checks = 0;

   matrix_engine #(.N(N4), .W(W4)) u_dut4 (
      .CLK        (clk),
      .reset      (rst),
      .cmd_valid  (d4_cmd_valid),
      .cmd_ready  (d4_cmd_ready),
      .command    (d4_command),
      .Matrix_in  (d4_in),
      .Matrix_out (d4_out),
      .out_valid  (d4_out_valid),
      .busy       (d4_busy),
      .done       (d4_done),
      .overflow   (d4_overflow)
   );

   matrix_engine #(.N(N2), .W(W2)) u_dut2 (
      .CLK        (clk),
      .reset      (rst),
      .cmd_valid  (d2_cmd_valid),
      .cmd_ready  (d2_cmd_ready),
      .command    (d2_command),
      .Matrix_in  (d2_in),
      .Matrix_out (d2_out),
      .out_valid  (d2_out_valid),
      .busy       (d2_busy),
      .done       (d2_done),
      .overflow   (d2_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // 4x4 matrix whose row-major elements are base, base+1, ...
   function automatic m4_t seq4(input int base);
      m4_t r = '0;
      for (int e = 0; e < 16; e++) r[e*21 +: 21] = 21'(base + e);
      return r;
   endfunction

   function automatic m4_t ident4();
      m4_t r = '0;
      for (int i = 0; i < 4; i++) r[(i*4+i)*21 +: 21] = 21'd1;
      return r;
   endfunction

   function automatic m2_t fill2(input int v);
      m2_t r = '0;
      for (int e = 0; e < 4; e++) r[e*8 +: 8] = 8'(v);
      return r;
   endfunction

   // Present a command on the 4x4 engine and step past its accept edge
   task automatic issue4(input logic [2:0] cmd, input m4_t m);
      int n;
      n = 0;
      @(negedge clk);
      while (!d4_cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (d4_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue4_ready: cmd_ready=%b required 1", d4_cmd_ready);
      end
      d4_cmd_valid = 1'b1;
      d4_command   = cmd;
      d4_in        = m;
      @(negedge clk);
      d4_cmd_valid = 1'b0;
      d4_command   = OP_NOP;
   endtask

   task automatic wait_idle4();
      int n;
      n = 0;
      while (!d4_cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (d4_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_idle4: cmd_ready=%b required 1 after %0d cycles", d4_cmd_ready, n);
      end
   endtask

   task automatic issue2(input logic [2:0] cmd, input m2_t m);
      int n;
      n = 0;
      @(negedge clk);
      while (!d2_cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (d2_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue2_ready: cmd_ready=%b required 1", d2_cmd_ready);
      end
      d2_cmd_valid = 1'b1;
      d2_command   = cmd;
      d2_in        = m;
      @(negedge clk);
      d2_cmd_valid = 1'b0;
      d2_command   = OP_NOP;
   endtask

   task automatic wait_idle2();
      int n;
      n = 0;
      while (!d2_cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (d2_cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_idle2: cmd_ready=%b required 1 after %0d cycles", d2_cmd_ready, n);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      d4_cmd_valid = 1'b0; d4_command = OP_NOP; d4_in = '0;
      d2_cmd_valid = 1'b0; d2_command = OP_NOP; d2_in = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({d4_cmd_ready, d4_busy, d4_done, d4_out_valid, d4_overflow} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_flags4: ready/busy/done/ov/ovf=%b required 10000",
                  {d4_cmd_ready, d4_busy, d4_done, d4_out_valid, d4_overflow});
      end
      checks++;
      if (d4_out !== '0) begin
         errors++;
         $display("FAIL reset_out4: Matrix_out=%h required 0", d4_out);
      end
      checks++;
      if ({d2_cmd_ready, d2_busy, d2_done, d2_out_valid, d2_overflow, d2_out} !== {5'b10000, 32'h0}) begin
         errors++;
         $display("FAIL reset_2: flags=%b out=%h required 10000 / 0",
                  {d2_cmd_ready, d2_busy, d2_done, d2_out_valid, d2_overflow}, d2_out);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({d4_cmd_ready, d4_busy, d4_done} !== 3'b100) begin
         errors++;
         $display("FAIL post_reset4: ready/busy/done=%b required 100", {d4_cmd_ready, d4_busy, d4_done});
      end
   endtask

   task automatic test_identity_mul();
      int cyc;
      issue4(OP_LOAD_A, ident4());
      checks++;
      if (d4_done !== 1'b1 || d4_busy !== 1'b1) begin
         errors++;
         $display("FAIL load_done: done=%b busy=%b required 1 1", d4_done, d4_busy);
      end
      wait_idle4();
      issue4(OP_LOAD_B, seq4(1));
      wait_idle4();
      issue4(OP_MUL, '0);
      checks++;
      if ({d4_busy, d4_cmd_ready, d4_out_valid, d4_done} !== 4'b1000) begin
         errors++;
         $display("FAIL mul_start: busy/ready/ov/done=%b required 1000",
                  {d4_busy, d4_cmd_ready, d4_out_valid, d4_done});
      end
      cyc = 0;
      while (!d4_done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != 16) begin
         errors++;
         $display("FAIL mul_latency: done after %0d edges required 16", cyc);
      end
      checks++;
      if (d4_out_valid !== 1'b0 || d4_busy !== 1'b1) begin
         errors++;
         $display("FAIL mul_finish: out_valid=%b busy=%b required 0 1", d4_out_valid, d4_busy);
      end
      @(negedge clk);
      checks++;
      if ({d4_out_valid, d4_done, d4_cmd_ready, d4_busy, d4_overflow} !== 5'b10100) begin
         errors++;
         $display("FAIL mul_end_flags: ov/done/ready/busy/ovf=%b required 10100",
                  {d4_out_valid, d4_done, d4_cmd_ready, d4_busy, d4_overflow});
      end
      checks++;
      if (d4_out !== seq4(1)) begin
         errors++;
         $display("FAIL ident_mul: C=%h required %h", d4_out, seq4(1));
      end
   endtask

   task automatic test_trans_handshake();
      m4_t exp_t;
      exp_t = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_t[(i*4+j)*21 +: 21] = 21'(j*4 + i);
      issue4(OP_LOAD_A, seq4(0));
      wait_idle4();
      issue4(OP_TRANS, '0);
      checks++;
      if (d4_done !== 1'b1) begin
         errors++;
         $display("FAIL trans_done: done=%b required 1", d4_done);
      end
      d4_cmd_valid = 1'b1;
      d4_command   = OP_MUL;
      @(negedge clk);
      checks++;
      if ({d4_busy, d4_cmd_ready, d4_out_valid} !== 3'b011) begin
         errors++;
         $display("FAIL hold_not_taken: busy/ready/ov=%b required 011",
                  {d4_busy, d4_cmd_ready, d4_out_valid});
      end
      checks++;
      if (d4_out !== exp_t) begin
         errors++;
         $display("FAIL trans: C=%h required %h", d4_out, exp_t);
      end
      @(negedge clk);
      d4_cmd_valid = 1'b0;
      d4_command   = OP_NOP;
      checks++;
      if ({d4_busy, d4_cmd_ready, d4_out_valid} !== 3'b100) begin
         errors++;
         $display("FAIL hold_taken: busy/ready/ov=%b required 100",
                  {d4_busy, d4_cmd_ready, d4_out_valid});
      end
      wait_idle4();
   endtask

   task automatic test_reset_mid_mul();
      issue4(OP_MUL, '0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({d4_cmd_ready, d4_busy, d4_out_valid, d4_done, d4_overflow} !== 5'b10000) begin
         errors++;
         $display("FAIL midreset_flags: ready/busy/ov/done/ovf=%b required 10000",
                  {d4_cmd_ready, d4_busy, d4_out_valid, d4_done, d4_overflow});
      end
      checks++;
      if (d4_out !== '0) begin
         errors++;
         $display("FAIL midreset_out: Matrix_out=%h required 0", d4_out);
      end
      @(negedge clk);
      rst = 1'b0;
      issue4(OP_LOAD_A, seq4(1));
      wait_idle4();
      issue4(OP_LOAD_B, ident4());
      wait_idle4();
      issue4(OP_MUL, '0);
      wait_idle4();
      checks++;
      if (d4_out !== seq4(1) || d4_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL remul: C=%h ov=%b required %h 1", d4_out, d4_out_valid, seq4(1));
      end
   endtask

   task automatic test_nop();
      m4_t exp_add;
      issue4(OP_NOP, seq4(100));
      checks++;
      if ({d4_done, d4_cmd_ready, d4_busy} !== 3'b010) begin
         errors++;
         $display("FAIL nop: done/ready/busy=%b required 010", {d4_done, d4_cmd_ready, d4_busy});
      end
      issue4(OP_RSVD, seq4(200));
      checks++;
      if ({d4_done, d4_cmd_ready, d4_busy} !== 3'b010) begin
         errors++;
         $display("FAIL rsvd: done/ready/busy=%b required 010", {d4_done, d4_cmd_ready, d4_busy});
      end
      checks++;
      if (d4_out !== seq4(1) || d4_out_valid !== 1'b1 || d4_overflow !== 1'b0) begin
         errors++;
         $display("FAIL nop_keep: C=%h ov=%b ovf=%b required %h 1 0",
                  d4_out, d4_out_valid, d4_overflow, seq4(1));
      end
      exp_add = seq4(1);
      for (int i = 0; i < 4; i++) exp_add[(i*5)*21 +: 21] = 21'(i*5 + 2);
      issue4(OP_ADD, '0);
      wait_idle4();
      checks++;
      if (d4_out !== exp_add) begin
         errors++;
         $display("FAIL nop_ab_kept: C=%h required %h", d4_out, exp_add);
      end
   endtask

   task automatic test_overflow();
      issue2(OP_LOAD_A, fill2(100));
      wait_idle2();
      issue2(OP_LOAD_B, fill2(1));
      wait_idle2();
      issue2(OP_MUL, '0);
      wait_idle2();
      checks++;
      if (d2_out !== 32'hC8C8C8C8 || d2_overflow !== 1'b1 || d2_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mul_ovf: C=%h ovf=%b ov=%b required c8c8c8c8 1 1",
                  d2_out, d2_overflow, d2_out_valid);
      end
      issue2(OP_LOAD_A, fill2(1));
      wait_idle2();
      checks++;
      if (d2_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_hold: overflow=%b required 1", d2_overflow);
      end
      issue2(OP_LOAD_B, fill2(2));
      wait_idle2();
      issue2(OP_ADD, '0);
      wait_idle2();
      checks++;
      if (d2_out !== 32'h03030303 || d2_overflow !== 1'b0) begin
         errors++;
         $display("FAIL add_clear: C=%h ovf=%b required 03030303 0", d2_out, d2_overflow);
      end
   endtask

   task automatic test_chaining();
      m2_t m;
      m = {8'd1, 8'd0, 8'd1, 8'd1};
      issue2(OP_LOAD_A, m);
      wait_idle2();
      issue2(OP_LOAD_B, m);
      wait_idle2();
      issue2(OP_MUL, '0);
      wait_idle2();
      checks++;
      if (d2_out !== {8'd1, 8'd0, 8'd2, 8'd1}) begin
         errors++;
         $display("FAIL chain_mul1: C=%h required 01000201", d2_out);
      end
      issue2(OP_COPY_CA, '0);
      wait_idle2();
      checks++;
      if (d2_out_valid !== 1'b1 || d2_out !== {8'd1, 8'd0, 8'd2, 8'd1}) begin
         errors++;
         $display("FAIL copy_ca: ov=%b C=%h required 1 01000201", d2_out_valid, d2_out);
      end
      issue2(OP_MUL, '0);
      wait_idle2();
      checks++;
      if (d2_out !== {8'd1, 8'd0, 8'd3, 8'd1} || d2_overflow !== 1'b0) begin
         errors++;
         $display("FAIL chain_mul2: C=%h ovf=%b required 01000301 0", d2_out, d2_overflow);
      end
   endtask

   initial begin
      test_reset();
      test_identity_mul();
      test_trans_handshake();
      test_reset_mid_mul();
      test_nop();
      test_overflow();
      test_chaining();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/matrix_engine.md
# matrix_engine

Parametrised N×N signed matrix coprocessor. Successor to the fixed 4×4/21-bit calculator. Holds operand registers A and B and a result register C, and executes a small command set: load, multiply, add, transpose, and copy-back for chaining. Multiply runs over N·N cycles, one output element per cycle. Sits between the host command path and downstream consumers of Matrix_out, using a valid/ready command handshake and a done pulse.

## Interface
- N, default 4: matrix dimension (≥2).
- W, default 21: element width, signed two's complement.
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept; high only in IDLE.
- command  in  3  opcode: 0 NOP, 1 LOAD_A, 2 LOAD_B, 3 MUL (C=A·B), 4 ADD (C=A+B), 5 TRANS (C=Aᵀ), 6 COPY_CA (A=C), 7 reserved.
- Matrix_in  in  N·N·W  operand; element (i,j) at bits [(i·N+j)·W +: W].
- Matrix_out  out  N·N·W  always drives register C, same packing.
- out_valid  out  1  C holds a completed result.
- busy  out  1  high in RUN and FINISH.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  last compute op produced at least one element not representable in W bits.

## Operation
- States: IDLE, RUN, FINISH.
- Accept: a command is accepted on an edge where cmd_valid && cmd_ready. Matrix_in is sampled only on LOAD_A or LOAD_B accept.
- LOAD_A / LOAD_B / ADD / TRANS / COPY_CA:
  - Target register is written at the accept edge.
  - IDLE→FINISH at that edge.
  - FINISH→IDLE on the next edge; done is high during FINISH.
- MUL:
  - IDLE→RUN at accept. Row-major counter k=0 on entry; out_valid cleared and overflow cleared.
  - Each RUN edge writes C[k/N][k%N] = dot(row A, col B), then increments k.
  - After the edge writing k=N·N−1: RUN→FINISH and k resets to 0.
- NOP and opcode 7: accepted, no state change, no done pulse, cmd_ready stays high.
- out_valid:
  - Set at the FINISH→IDLE edge of MUL, ADD, TRANS.
  - Cleared at MUL accept.
  - Unaffected by loads and COPY_CA.
- overflow:
  - Cleared at accept of MUL, ADD, TRANS.
  - Set if any written element overflows.
  - Holds until the next such accept.
- Arithmetic:
  - Products are 2W bits. The dot product is accumulated at 2W+clog2(N) bits with no intermediate loss.
  - ADD is computed at W+1 bits.
  - Stored value is the low W bits (wrap). Overflow is flagged when the full value falls outside [−2^(W−1), 2^(W−1)−1].
- Commands presented while cmd_ready is low are ignored; upstream must hold them.
- Reset, including mid-RUN: state IDLE; k=0; A, B, C zero; all outputs low except cmd_ready=1. The partial MUL is discarded.

## Timing
- Reset values: cmd_ready 1; busy 0; done 0; out_valid 0; overflow 0; Matrix_out 0.
- MUL latency:
  - Accept edge E0; C elements written at E1..E(N·N).
  - done and busy high in the cycle after E(N·N).
  - cmd_ready high again after E(N·N+1).
  - Throughput is one MUL per N·N+2 cycles.
- Single-cycle ops: written at E0, done in the cycle after E0, next accept possible at E2.
- Matrix_out is visible mid-MUL with partially updated C. It is valid only when out_valid=1.
- done and out_valid are registered outputs. cmd_ready and busy decode directly from the state register.

## Structure
- Package mc_pkg holds:
  - The opcode enum (cmd_t).
  - The state enum (state_t).
  - Element-slice helper functions.
  - The accumulator-width localparam derivation.
- Sub-module mc_dot_unit, combinational:
  - N signed multipliers plus an adder tree.
  - Inputs: one row of A and one column of B.
  - Outputs: the W-bit truncated result and an overflow bit.
  - Instantiated once and reused across k.
- The top level holds the FSM, counter, A/B/C registers, and the ADD/TRANS datapaths.

## Test plan
- Identity multiply (N=4, W=21): LOAD_A=I, LOAD_B=elements 1..16, MUL → C=B; done exactly 16 cycles after accept edge; out_valid rises with done's falling edge; overflow 0.
- Overflow (N=2, W=8): A all 100, B all 1, MUL → every element 0xC8 (−56), overflow=1. Next ADD of A=1s, B=2s → C all 3, overflow=0.
- Chaining: A=[[1,1],[0,1]], B=same, MUL, COPY_CA, MUL → C=[[1,3],[0,1]]; COPY_CA leaves out_valid=1.
- TRANS plus handshake: A=elements 0..15, TRANS → C(i,j)=A(j,i). Hold cmd_valid=1 with MUL during FINISH → not accepted until cmd_ready returns.
- Reset mid-MUL: assert reset after the 5th RUN edge → immediately cmd_ready=1, busy=0, Matrix_out=0, out_valid=0. The next MUL with reloaded operands gives the correct result.
- NOP and opcode 7 in IDLE → no done pulse; A, B, C and flags unchanged.
